// File: rtl/pipeline_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, register-zero constant
// and the default memory-wait timeout, plus the load-use hazard predicate.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO               = 5'd0;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 64;

  // A load into $0 never creates a dependency, so it never stalls.
  function automatic logic is_load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_wait_timer.sv
// Saturating wait-cycle counter with a sticky timeout flag; usable for any
// memory port that can hold off the pipeline.
module hazard_wait_timer
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_inc,
  input  logic i_clear,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_nextCount;
  logic          r_timeout;

  always_comb begin
    w_nextCount = r_count;
    if (i_clear) begin
      w_nextCount = '0;
    end else if (i_start) begin
      w_nextCount = CW'(1);
    end else if (i_inc && (r_count < LIMIT)) begin
      w_nextCount = r_count + CW'(1);
    end
  end

  // The flag is sticky: only reset clears it, even after the wait resolves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_count <= w_nextCount;
      if (w_nextCount >= LIMIT) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush/freeze control for hazards that forwarding cannot resolve.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_unit
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_RS,
  input  logic [4:0]       IF_ID_RT,
  input  logic             ID_UsesRT,
  input  logic [4:0]       ID_EX_RT,
  input  logic             ID_EX_MemRead,
  input  logic             ID_Jump,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             Mem_Timeout
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] Stall_Cycles
  , output logic [CNT_W-1:0] Flush_Count
`endif
);

  hazard_state_t r_state;
  hazard_state_t w_nextState;
  logic          w_memWait;
  logic          w_loadUse;
  logic          w_timerStart;
  logic          w_timerInc;
  logic          w_timerClear;

  assign w_memWait = MEM_Req && !MEM_Ready;
  assign w_loadUse = is_load_use(ID_EX_MemRead, ID_EX_RT, IF_ID_RS, IF_ID_RT, ID_UsesRT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // LOAD_STALL evaluates hazards exactly like RUN but can never chain a second stall.
  always_comb begin
    w_nextState  = r_state;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    w_timerStart = 1'b0;
    w_timerInc   = 1'b0;
    w_timerClear = 1'b0;
    unique case (r_state)
      RUN, LOAD_STALL: begin
        w_nextState = RUN;
        if (w_memWait) begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          EX_MEM_Write = 1'b0;
          w_timerStart = 1'b1;
          w_nextState  = MEM_WAIT;
        end else if (EX_BranchTaken) begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
        end else if (w_loadUse) begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
          if (r_state == RUN) begin
            w_nextState = LOAD_STALL;
          end
        end else if (ID_Jump) begin
          IF_ID_Flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (w_memWait) begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          EX_MEM_Write = 1'b0;
          w_timerInc   = 1'b1;
        end else begin
          w_timerClear = 1'b1;
          w_nextState  = RUN;
        end
      end
      default: w_nextState = RUN;
    endcase
    if (!reset) begin
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Flush  = 1'b0;
      EX_MEM_Write = 1'b1;
    end
  end

  hazard_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_waitTimer (
    .clk      (clk),
    .rst_n    (reset),
    .i_start  (w_timerStart),
    .i_inc    (w_timerInc),
    .i_clear  (w_timerClear),
    .o_timeout(Mem_Timeout)
  );

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushCount;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      if (!PC_Write && (r_stallCycles != '1)) begin
        r_stallCycles <= r_stallCycles + CNT_W'(1);
      end
      if ((IF_ID_Flush || ID_EX_Flush) && (r_flushCount != '1)) begin
        r_flushCount <= r_flushCount + CNT_W'(1);
      end
    end
  end

  assign Stall_Cycles = r_stallCycles;
  assign Flush_Count  = r_flushCount;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: expected control vectors are queued as
// stimulus is driven and compared mid-cycle against the combinational outputs.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] IF_ID_RS = '0;
  logic [4:0] IF_ID_RT = '0;
  logic       ID_UsesRT = 1'b0;
  logic [4:0] ID_EX_RT = '0;
  logic       ID_EX_MemRead = 1'b0;
  logic       ID_Jump = 1'b0;
  logic       EX_BranchTaken = 1'b0;
  logic       MEM_Req = 1'b0;
  logic       MEM_Ready = 1'b0;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       EX_MEM_Write;
  logic       Mem_Timeout;
`ifdef HAZARD_STATS_EN
  logic [15:0] Stall_Cycles;
  logic [15:0] Flush_Count;
`endif

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, Mem_Timeout}
  localparam logic [5:0] NORMAL = 6'b110010;
  localparam logic [5:0] STALL  = 6'b000110;
  localparam logic [5:0] BRANCH = 6'b111110;
  localparam logic [5:0] JUMP   = 6'b111010;
  localparam logic [5:0] FREEZE = 6'b000000;

  logic [5:0] expQ[$];
  logic [5:0] got;
  logic [5:0] want;
  int         compared = 0;
  int         mismatched = 0;

  wire [5:0] obs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, Mem_Timeout};

  hazard_stall_unit dut (
    .clk           (clk),
    .reset         (reset),
    .IF_ID_RS      (IF_ID_RS),
    .IF_ID_RT      (IF_ID_RT),
    .ID_UsesRT     (ID_UsesRT),
    .ID_EX_RT      (ID_EX_RT),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_Jump       (ID_Jump),
    .EX_BranchTaken(EX_BranchTaken),
    .MEM_Req       (MEM_Req),
    .MEM_Ready     (MEM_Ready),
    .PC_Write      (PC_Write),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_Flush   (IF_ID_Flush),
    .ID_EX_Flush   (ID_EX_Flush),
    .EX_MEM_Write  (EX_MEM_Write),
    .Mem_Timeout   (Mem_Timeout)
`ifdef HAZARD_STATS_EN
    , .Stall_Cycles(Stall_Cycles)
    , .Flush_Count (Flush_Count)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus word: {memRead, exRt, rs, rt, usesRt, jump, branch, req, ready}
  function automatic logic [20:0] mk(input logic memRead, input logic [4:0] exRt,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic usesRt, input logic jump,
                                     input logic branch, input logic req,
                                     input logic ready);
    return {memRead, exRt, rs, rt, usesRt, jump, branch, req, ready};
  endfunction

  task automatic applyStimulus(input logic [20:0] s);
    {ID_EX_MemRead, ID_EX_RT, IF_ID_RS, IF_ID_RT, ID_UsesRT,
     ID_Jump, EX_BranchTaken, MEM_Req, MEM_Ready} = s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    applyStimulus(mk(1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 1, 0));
    expQ.push_back(NORMAL);
    #2;
    got = obs;
    want = expQ.pop_front();
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL reset_forced: observed %b expected %b", got, want);
    end
    @(posedge clk);
    #1;
    applyStimulus('0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    logic [20:0] stim[5];
    logic [5:0]  exp[5];
    stim[0] = mk(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 0);  exp[0] = STALL;
    stim[1] = mk(0, 5'd0, 5'd8, 5'd0, 0, 0, 0, 0, 0);  exp[1] = NORMAL;
    stim[2] = mk(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);  exp[2] = NORMAL;
    stim[3] = mk(1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0, 0);  exp[3] = NORMAL;
    stim[4] = mk(1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0, 0);  exp[4] = STALL;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(stim[i]);
      expQ.push_back(exp[i]);
      @(negedge clk);
      got = obs;
      want = expQ.pop_front();
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL load_use[%0d]: observed %b expected %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
    applyStimulus('0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_branch_jump();
    logic [20:0] stim[5];
    logic [5:0]  exp[5];
    stim[0] = mk(1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 0, 0);  exp[0] = BRANCH;
    stim[1] = mk(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 0);  exp[1] = STALL;
    stim[2] = mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);  exp[2] = JUMP;
    stim[3] = mk(1, 5'd4, 5'd4, 5'd0, 0, 1, 0, 0, 0);  exp[3] = STALL;
    stim[4] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);  exp[4] = NORMAL;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(stim[i]);
      expQ.push_back(exp[i]);
      @(negedge clk);
      got = obs;
      want = expQ.pop_front();
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL branch_jump[%0d]: observed %b expected %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_wait();
    logic [20:0] stim[11];
    logic [5:0]  exp[11];
    stim[0]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);  exp[0]  = FREEZE;
    stim[1]  = mk(1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 1, 0);  exp[1]  = FREEZE;
    stim[2]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);  exp[2]  = FREEZE;
    stim[3]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1);  exp[3]  = NORMAL;
    stim[4]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);  exp[4]  = BRANCH;
    stim[5]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);  exp[5]  = FREEZE;
    stim[6]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);  exp[6]  = NORMAL;
    stim[7]  = mk(1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0);  exp[7]  = STALL;
    stim[8]  = mk(0, 5'd0, 5'd7, 5'd0, 0, 0, 0, 1, 0);  exp[8]  = FREEZE;
    stim[9]  = mk(0, 5'd0, 5'd7, 5'd0, 0, 0, 0, 1, 1);  exp[9]  = NORMAL;
    stim[10] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);  exp[10] = NORMAL;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(stim[i]);
      expQ.push_back(exp[i]);
      @(negedge clk);
      got = obs;
      want = expQ.pop_front();
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL mem_wait[%0d]: observed %b expected %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_timeout();
    applyStimulus(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0));
    for (int c = 1; c <= 67; c++) begin
      expQ.push_back({5'b00000, (c >= 65) ? 1'b1 : 1'b0});
      @(negedge clk);
      got = obs;
      want = expQ.pop_front();
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL timeout_wait[%0d]: observed %b expected %b", c, got, want);
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, (i == 0)));
      expQ.push_back((i == 0) ? 6'b110011 : 6'b000001);
      @(negedge clk);
      got = obs;
      want = expQ.pop_front();
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL timeout_sticky[%0d]: observed %b expected %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    expQ.push_back(NORMAL);
    #2;
    got = obs;
    want = expQ.pop_front();
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_wait: observed %b expected %b", got, want);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(mk(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0));
    expQ.push_back(STALL);
    @(negedge clk);
    got = obs;
    want = expQ.pop_front();
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL run_after_reset: observed %b expected %b", got, want);
    end
    @(posedge clk);
    #1;
    applyStimulus('0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump();
    test_mem_wait();
    test_timeout();
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: observed %0d leftover expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
